vga_pattern_gen: RTL
====================

// Module: vga_pattern_gen
// PURPOSE
//  Parametrised VGA test-pattern generator; successor to the fixed 640x480 colour-band pattern.
//  Sits between the VGA timing controller (pixel X/Y/DE) and the DAC outputs.
//  Four run-time modes: band gradient, checkerboard, scrolling bands, solid colour. Mode changes only at frame boundaries.
//  Band indices come from incremental counters; no dividers or comparator chains.
// PARAMETERS
//  COLOR_W         10   bits per colour channel
//  H_ACTIVE        640  active pixels per line; must be divisible by 2^H_BANDS_LOG2
//  V_ACTIVE        480  active lines per frame; must be divisible by 2^V_BANDS_LOG2
//  H_BANDS_LOG2    3    log2 of the number of horizontal bands; H_BAND_W = H_ACTIVE>>H_BANDS_LOG2
//  V_BANDS_LOG2    3    log2 of the number of vertical bands (>=1); V_BAND_H = V_ACTIVE>>V_BANDS_LOG2
//  SCROLL_DIV_LOG2 3    mode 2 advances one band every 2^SCROLL_DIV_LOG2 frames
//  FRAME_CNT_W     16   frame counter width
// PORTS
//  iVGA_CLK   in   1            pixel clock
//  iRST       in   1            asynchronous reset, active-high
//  iVGA_X     in   10           current pixel column
//  iVGA_Y     in   10           current pixel row
//  iDE        in   1            active-video qualifier for iVGA_X/iVGA_Y
//  iMODE      in   2            0 bands, 1 checker, 2 scroll, 3 solid
//  iSOLID     in   3*COLOR_W    {R,G,B} colour for mode 3
//  oRed       out  COLOR_W      red pixel
//  oGreen     out  COLOR_W      green pixel
//  oBlue      out  COLOR_W      blue pixel
//  oDE        out  1            iDE delayed to align with colour outputs
//  oFRAME_CNT out  FRAME_CNT_W  completed-frame counter
// BEHAVIOUR
//  - Reset: all outputs 0, mode reg 0, counters 0, sync flag 0. Async assert; deassert takes effect on the next iVGA_CLK edge.
//  - Frame start (FS) = iDE & X==0 & Y==0. Line start (LS) = iDE & X==0 & !FS.
//  - Sync flag is set on the first FS after reset. While it is clear, oDE=0 and colours=0.
//  - Pipeline latency is 2 clocks: stage 1 registers hband/vband/mode/DE; stage 2 registers the colour and oDE.
//  - oDE low at stage 2 forces the colour outputs to 0.
//  - H counter: FS/LS pixel gets hband=0 and hcnt is set to 1. Each further iDE pixel increments hcnt.
//    At hcnt==H_BAND_W, hcnt wraps and hband increments, saturating at 2^H_BANDS_LOG2-1 (overlong lines stay in the last band).
//    Counters hold while iDE=0.
//  - V counter: FS clears vcnt and vband. At each LS, vcnt increments; at vcnt==V_BAND_H-1 it wraps and vband
//    increments, saturating at 2^V_BANDS_LOG2-1.
//  - Mode reg: iMODE is sampled only at FS; a mid-frame change takes effect at the next frame.
//  - oFRAME_CNT: increments at each FS after the one that sets sync; wraps modulo 2^FRAME_CNT_W.
//  - Level function: lvl(b,L) = (b+1)<<(COLOR_W-L), saturated to 2^COLOR_W-1.
//  - MAX = 2^COLOR_W-1; NV = 2^V_BANDS_LOG2.
//  - Mode 0: R=lvl(vband>>1, V_BANDS_LOG2-1); G=lvl(hband, H_BANDS_LOG2); B=lvl(NV-1-vband, V_BANDS_LOG2).
//  - Mode 1: hband[0]^vband[0] ? {MAX,MAX,MAX} : 0.
//  - Mode 2: as mode 0, but G uses (hband + (oFRAME_CNT>>SCROLL_DIV_LOG2)) mod 2^H_BANDS_LOG2. The scroll term is sampled at FS.
//  - Mode 3: {R,G,B} = iSOLID, sampled at FS.
//  - Reset mid-frame: outputs blank immediately; output resumes at the next FS, with the counter and mode cleared.
// TESTING
//  1. iRST=1 -> all outputs 0. Release iRST, drive pixels from X=5,Y=5 -> oDE=0 until an FS, then oDE follows iDE 2 clocks later.
//  2. Mode 0 defaults. (X=85,Y=130) -> R=512,G=256,B=768 two clocks later.
//     (X=0,Y=0) -> 256,128,1023. (X=639,Y=479) -> 1023,1023,128.
//  3. Mode 1 -> (X=0,Y=0) gives 0,0,0. (X=80,Y=0) gives 1023 on all channels. (X=80,Y=60) gives 0.
//  4. Switch iMODE 0->3 at Y=200 with iSOLID={10'd5,10'd6,10'd7} -> rest of frame stays mode 0; from the next FS all pixels are 5,6,7.
//  5. Mode 2 with SCROLL_DIV_LOG2=0 -> frame with oFRAME_CNT=1: G at X=0 is 256. oFRAME_CNT=7: G at X=80 is 128 (wrap).
//  6. FRAME_CNT_W=4 over 17 frames -> count wraps 15->0. Line of 700 iDE pixels -> pixels 640..699 have G=1023 (saturated band).

Source files
------------

// File: rtl/vga_pattern_gen.sv
// VGA test-pattern generator: band gradient, checkerboard, scrolling bands, solid colour.
// Two-stage pipeline from pixel X/Y/DE to DAC colour; band indices come from running counters.
module vga_pattern_gen #(
  parameter int COLOR_W         = 10,
  parameter int H_ACTIVE        = 640,
  parameter int V_ACTIVE        = 480,
  parameter int H_BANDS_LOG2    = 3,
  parameter int V_BANDS_LOG2    = 3,
  parameter int SCROLL_DIV_LOG2 = 3,
  parameter int FRAME_CNT_W     = 16
) (
  input  logic                     iVGA_CLK,
  input  logic                     iRST,
  input  logic [9:0]               iVGA_X,
  input  logic [9:0]               iVGA_Y,
  input  logic                     iDE,
  input  logic [1:0]               iMODE,
  input  logic [3*COLOR_W-1:0]     iSOLID,
  output logic [COLOR_W-1:0]       oRed,
  output logic [COLOR_W-1:0]       oGreen,
  output logic [COLOR_W-1:0]       oBlue,
  output logic                     oDE,
  output logic [FRAME_CNT_W-1:0]   oFRAME_CNT
);

  localparam int STAGES   = 2;
  localparam int HB       = H_BANDS_LOG2;
  localparam int VB       = V_BANDS_LOG2;
  localparam int NV       = 1 << VB;
  localparam int MAX_I    = (1 << COLOR_W) - 1;
  localparam int H_BAND_W = H_ACTIVE >> HB;
  localparam int V_BAND_H = V_ACTIVE >> VB;
  localparam int HCW      = $clog2(H_BAND_W + 1);
  localparam int VCW      = (V_BAND_H > 1) ? $clog2(V_BAND_H) : 1;

  localparam logic [HCW-1:0]     HCNT_WRAP = HCW'(H_BAND_W);
  localparam logic [VCW-1:0]     VCNT_LAST = VCW'(V_BAND_H - 1);
  localparam logic [HB-1:0]      HB_LAST   = '1;
  localparam logic [VB-1:0]      VB_LAST   = '1;
  localparam logic [COLOR_W-1:0] MAX       = '1;

  typedef enum logic [1:0] {
    MODE_BANDS  = 2'd0,
    MODE_CHECK  = 2'd1,
    MODE_SCROLL = 2'd2,
    MODE_SOLID  = 2'd3
  } mode_e;

  typedef struct packed {
    logic [HB-1:0] hb;
    logic [VB-1:0] vb;
    mode_e         mode;
  } pix_s;

  // (b+1) scaled to the top of the channel range, clipped at full scale
  function automatic logic [COLOR_W-1:0] lvl(input int b, input int l);
    int v;
    v = (b + 1) << (COLOR_W - l);
    return (v > MAX_I) ? MAX : v[COLOR_W-1:0];
  endfunction

  logic x0, fs, ls, deIn;
  assign x0   = iDE && (iVGA_X == '0);
  assign fs   = x0 && (iVGA_Y == '0);
  assign ls   = x0 && !fs;

  // frame-scope state
  logic                   syncR;
  mode_e                  modeR;
  logic [3*COLOR_W-1:0]   solidR;
  logic [HB-1:0]          scrollR;
  logic [FRAME_CNT_W-1:0] frameNxt;

  assign deIn     = iDE && (syncR || fs);
  assign frameNxt = syncR ? oFRAME_CNT + FRAME_CNT_W'(1) : oFRAME_CNT;

  always_ff @(posedge iVGA_CLK or posedge iRST) begin
    if (iRST) begin
      syncR      <= 1'b0;
      modeR      <= MODE_BANDS;
      solidR     <= '0;
      scrollR    <= '0;
      oFRAME_CNT <= '0;
    end else if (fs) begin
      syncR      <= 1'b1;
      modeR      <= mode_e'(iMODE);
      solidR     <= iSOLID;
      scrollR    <= frameNxt[SCROLL_DIV_LOG2 +: HB];
      oFRAME_CNT <= frameNxt;
    end
  end

  // band counters; hbCur/vbCur are the bands of the pixel currently at the input
  logic [HCW-1:0] hcnt, hcntNxt;
  logic [VCW-1:0] vcnt, vcntNxt;
  logic [HB-1:0]  hbandR, hbCur;
  logic [VB-1:0]  vbandR, vbCur;

  always_comb begin
    hcntNxt = hcnt;
    hbCur   = hbandR;
    if (x0) begin
      hcntNxt = HCW'(1);
      hbCur   = '0;
    end else if (iDE) begin
      if (hcnt == HCNT_WRAP) begin
        hcntNxt = HCW'(1);
        hbCur   = (hbandR == HB_LAST) ? hbandR : hbandR + HB'(1);
      end else begin
        hcntNxt = hcnt + HCW'(1);
      end
    end
  end

  always_comb begin
    vcntNxt = vcnt;
    vbCur   = vbandR;
    if (fs) begin
      vcntNxt = '0;
      vbCur   = '0;
    end else if (ls) begin
      if (vcnt == VCNT_LAST) begin
        vcntNxt = '0;
        vbCur   = (vbandR == VB_LAST) ? vbandR : vbandR + VB'(1);
      end else begin
        vcntNxt = vcnt + VCW'(1);
      end
    end
  end

  always_ff @(posedge iVGA_CLK or posedge iRST) begin
    if (iRST) begin
      hcnt   <= '0;
      hbandR <= '0;
      vcnt   <= '0;
      vbandR <= '0;
    end else begin
      hcnt   <= hcntNxt;
      hbandR <= hbCur;
      vcnt   <= vcntNxt;
      vbandR <= vbCur;
    end
  end

  // stage 1: bands, mode and qualified DE
  pix_s                s1;
  logic [STAGES:1]     vldPipe;

  always_ff @(posedge iVGA_CLK or posedge iRST) begin
    if (iRST) begin
      s1      <= '0;
      vldPipe <= '0;
    end else begin
      s1.hb   <= hbCur;
      s1.vb   <= vbCur;
      s1.mode <= fs ? mode_e'(iMODE) : modeR;
      vldPipe <= {vldPipe[STAGES-1:1], deIn};
    end
  end

  // stage 2: colour; frame regs switch on the same edge that captures the FS pixel
  logic [HB-1:0]      gBand;
  logic [COLOR_W-1:0] rNxt, gNxt, bNxt;

  assign gBand = (s1.mode == MODE_SCROLL) ? s1.hb + scrollR : s1.hb;

  always_comb begin
    rNxt = '0;
    gNxt = '0;
    bNxt = '0;
    if (vldPipe[1]) begin
      unique case (s1.mode)
        MODE_BANDS, MODE_SCROLL: begin
          rNxt = lvl(int'(s1.vb) >> 1, VB - 1);
          gNxt = lvl(int'(gBand), HB);
          bNxt = lvl(NV - 1 - int'(s1.vb), VB);
        end
        MODE_CHECK: begin
          if (s1.hb[0] ^ s1.vb[0]) begin
            rNxt = MAX;
            gNxt = MAX;
            bNxt = MAX;
          end
        end
        MODE_SOLID: {rNxt, gNxt, bNxt} = solidR;
        default: ;
      endcase
    end
  end

  always_ff @(posedge iVGA_CLK or posedge iRST) begin
    if (iRST) begin
      oRed   <= '0;
      oGreen <= '0;
      oBlue  <= '0;
    end else begin
      oRed   <= rNxt;
      oGreen <= gNxt;
      oBlue  <= bNxt;
    end
  end

  assign oDE = vldPipe[STAGES];

endmodule
